mem_access_stage: RTL and testbench

MEM stage of the pipelined MIPS core: the consumer of the EX/MEM pipeline register. It reads the latched EX/MEM fields and resolves the branch (PC source and target). It performs the data-memory access over a req/ack handshake, so memory may take several cycles, and stalls the upstream pipeline until that access completes. It then loads the MEM/WB register that feeds write-back.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mem_wb_reg.sv | 50 +++++
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MEM stage and the MEM/WB register.
//   state_t         : MEM-stage access FSM states (IDLE, REQ)
//   DATA_W / REG_W  : default datapath width and register-index width
//   TIMEOUT_DEFAULT : default number of REQ cycles before an access is
//                     abandoned (used only when MEM_ACK_TIMEOUT_EN is defined)
package mips_pkg;

    localparam int DATA_W          = 32;
    localparam int REG_W           = 5;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with a capture/bubble select.
// On each rising edge it either loads the src_* fields (capture = 1) or
// loads a bubble (all outputs 0). rst_n is synchronous, active-low.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   capture                         1 = load src_* fields, 0 = load bubble
//   src_reg_write, src_mem_to_reg   control fields to latch
//   src_read_data, src_alu          data fields to latch (DATA_W)
//   src_dest                        destination register (REG_W)
//   reg_write, mem_to_reg           registered control outputs
//   read_data, alu                  registered data outputs
//   dest                            registered destination
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              src_reg_write,
    input  logic              src_mem_to_reg,
    input  logic [DATA_W-1:0] src_read_data,
    input  logic [DATA_W-1:0] src_alu,
    input  logic [REG_W-1:0]  src_dest,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] alu,
    output logic [REG_W-1:0]  dest
);

    always_ff @(posedge clk) begin
        if (!rst_n || !capture) begin
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            read_data  <= '0;
            alu        <= '0;
            dest       <= '0;
        end else begin
            reg_write  <= src_reg_write;
            mem_to_reg <= src_mem_to_reg;
            read_data  <= src_read_data;
            alu        <= src_alu;
            dest       <= src_dest;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the pipelined MIPS core.
// Consumes the EX/MEM register, resolves the branch, runs the data-memory
// access over a req/ack handshake (stalling upstream while it is in flight)
// and loads the MEM/WB register.
// Optional feature: define MEM_ACK_TIMEOUT_EN to abandon an access after
// TIMEOUT REQ cycles without ack and raise the sticky mem_err flag.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   exmem_*                         latched EX/MEM fields
//   dmem_req/we/addr/wdata          registered memory request (out)
//   dmem_ack, dmem_rdata            memory completion strobe and read data
//   stall                           freezes PC, IF/ID, ID/EX, EX/MEM
//   pc_src, branch_target           branch decision and target
//   memwb_*                         MEM/WB register outputs
//   mem_err                         sticky access-timeout flag
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int REG_W   = mips_pkg::REG_W,
    parameter int TIMEOUT = mips_pkg::TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exmem_branch,
    input  logic              exmem_mem_write,
    input  logic              exmem_mem_read,
    input  logic              exmem_reg_write,
    input  logic              exmem_mem_to_reg,
    input  logic [DATA_W-1:0] exmem_add,
    input  logic [DATA_W-1:0] exmem_alu,
    input  logic [DATA_W-1:0] exmem_b2,
    input  logic [REG_W-1:0]  exmem_mux,
    input  logic              exmem_zf,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              memwb_reg_write,
    output logic              memwb_mem_to_reg,
    output logic [DATA_W-1:0] memwb_read_data,
    output logic [DATA_W-1:0] memwb_alu,
    output logic [REG_W-1:0]  memwb_dest,
    output logic              mem_err
);

    state_t            state;
    state_t            next_state;
    logic              mem_op;
    logic              start;
    logic              capture;
    logic              timeout_hit;
    logic [DATA_W-1:0] capture_read_data;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("mem_access_stage: TIMEOUT must be at least 1");
    end

    assign mem_op = exmem_mem_read | exmem_mem_write;

    // dmem_req comes straight from the state register, so ack never reaches
    // it combinationally.
    assign dmem_req = (state == REQ);

    assign branch_target = exmem_add;
    assign pc_src        = exmem_branch & exmem_zf & ~stall;

    // Only a completed read returns memory data; stores (including the
    // read+write case, handled as a store) and ALU ops write back 0.
    assign capture_read_data = (state == REQ && !dmem_we) ? dmem_rdata : '0;

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        capture    = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall      = 1'b1;
                    start      = 1'b1;
                    next_state = REQ;
                end else begin
                    capture = 1'b1;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end else if (timeout_hit) begin
                    // Abandoned access: release upstream, retire as a bubble.
                    next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                dmem_we    <= exmem_mem_write;
                dmem_addr  <= exmem_alu;
                dmem_wdata <= exmem_b2;
            end
        end
    end

`ifdef MEM_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] req_cnt;

    // req_cnt holds the number of completed REQ cycles; the TIMEOUT-th REQ
    // cycle without ack is the last one.
    assign timeout_hit = (state == REQ) && (req_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            if (start) begin
                req_cnt <= '0;
            end else if (state == REQ) begin
                req_cnt <= req_cnt + 1'b1;
            end
            if (timeout_hit && !dmem_ack) begin
                mem_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .capture        (capture),
        .src_reg_write  (exmem_reg_write),
        .src_mem_to_reg (exmem_mem_to_reg),
        .src_read_data  (capture_read_data),
        .src_alu        (exmem_alu),
        .src_dest       (exmem_mux),
        .reg_write      (memwb_reg_write),
        .mem_to_reg     (memwb_mem_to_reg),
        .read_data      (memwb_read_data),
        .alu            (memwb_alu),
        .dest           (memwb_dest)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench for mem_access_stage.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns after
// the edge (registered) or 1 ns after an input change (combinational).
// The timeout scenario is compiled in only when MEM_ACK_TIMEOUT_EN is defined.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        exmem_branch;
    logic        exmem_mem_write;
    logic        exmem_mem_read;
    logic        exmem_reg_write;
    logic        exmem_mem_to_reg;
    logic [31:0] exmem_add;
    logic [31:0] exmem_alu;
    logic [31:0] exmem_b2;
    logic [4:0]  exmem_mux;
    logic        exmem_zf;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        memwb_reg_write;
    logic        memwb_mem_to_reg;
    logic [31:0] memwb_read_data;
    logic [31:0] memwb_alu;
    logic [4:0]  memwb_dest;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    mem_access_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exmem_branch     (exmem_branch),
        .exmem_mem_write  (exmem_mem_write),
        .exmem_mem_read   (exmem_mem_read),
        .exmem_reg_write  (exmem_reg_write),
        .exmem_mem_to_reg (exmem_mem_to_reg),
        .exmem_add        (exmem_add),
        .exmem_alu        (exmem_alu),
        .exmem_b2         (exmem_b2),
        .exmem_mux        (exmem_mux),
        .exmem_zf         (exmem_zf),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .stall            (stall),
        .pc_src           (pc_src),
        .branch_target    (branch_target),
        .memwb_reg_write  (memwb_reg_write),
        .memwb_mem_to_reg (memwb_mem_to_reg),
        .memwb_read_data  (memwb_read_data),
        .memwb_alu        (memwb_alu),
        .memwb_dest       (memwb_dest),
        .mem_err          (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        exmem_branch     = 1'b0;
        exmem_mem_write  = 1'b0;
        exmem_mem_read   = 1'b0;
        exmem_reg_write  = 1'b0;
        exmem_mem_to_reg = 1'b0;
        exmem_add        = 32'h0;
        exmem_alu        = 32'h0;
        exmem_b2         = 32'h0;
        exmem_mux        = 5'd0;
        exmem_zf         = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        tick();
        tick();

        // Reset state
        chk1 ("reset_req",       dmem_req, 1'b0);
        chk1 ("reset_we",        dmem_we, 1'b0);
        chk32("reset_addr",      dmem_addr, 32'h0);
        chk1 ("reset_memwb_rw",  memwb_reg_write, 1'b0);
        chk32("reset_memwb_rd",  memwb_read_data, 32'h0);
        chk1 ("reset_stall",     stall, 1'b0);
        chk1 ("reset_err",       mem_err, 1'b0);
        rst_n = 1'b1;

        // R-type pass-through: one-cycle latency, no stall
        exmem_alu       = 32'h0000_0010;
        exmem_mux       = 5'd5;
        exmem_reg_write = 1'b1;
        #1;
        chk1("rtype_stall", stall, 1'b0);
        tick();
        chk32("rtype_alu",  memwb_alu, 32'h10);
        chk32("rtype_dest", {27'b0, memwb_dest}, 32'd5);
        chk1 ("rtype_rw",   memwb_reg_write, 1'b1);
        chk32("rtype_rd",   memwb_read_data, 32'h0);
        nop();

        // Load, ack on the 3rd REQ cycle
        exmem_alu        = 32'h100;
        exmem_mem_read   = 1'b1;
        exmem_mem_to_reg = 1'b1;
        exmem_reg_write  = 1'b1;
        exmem_mux        = 5'd8;
        #1;
        chk1("load_detect_stall", stall, 1'b1);
        chk1("load_detect_req",   dmem_req, 1'b0);
        tick();
        chk1 ("load_req1_req",    dmem_req, 1'b1);
        chk32("load_req1_addr",   dmem_addr, 32'h100);
        chk1 ("load_req1_we",     dmem_we, 1'b0);
        chk1 ("load_req1_stall",  stall, 1'b1);
        chk1 ("load_req1_bubble", memwb_reg_write, 1'b0);
        tick();
        chk1("load_req2_stall", stall, 1'b1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_BABE;
        #1;
        chk1("load_ack_stall", stall, 1'b0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        chk32("load_rd",   memwb_read_data, 32'hCAFE_BABE);
        chk1 ("load_m2r",  memwb_mem_to_reg, 1'b1);
        chk1 ("load_rw",   memwb_reg_write, 1'b1);
        chk32("load_dest", {27'b0, memwb_dest}, 32'd8);
        chk1 ("load_done_req", dmem_req, 1'b0);

        // Store, ack on the 1st REQ cycle
        exmem_alu       = 32'h40;
        exmem_b2        = 32'h1234;
        exmem_mem_write = 1'b1;
        #1;
        chk1("store_detect_stall", stall, 1'b1);
        tick();
        chk1 ("store_we",    dmem_we, 1'b1);
        chk32("store_wdata", dmem_wdata, 32'h1234);
        chk32("store_addr",  dmem_addr, 32'h40);
        chk1 ("store_req",   dmem_req, 1'b1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk1("store_ack_stall", stall, 1'b0);
        tick();
        dmem_ack = 1'b0;
        nop();
        chk1 ("store_rw",  memwb_reg_write, 1'b0);
        chk32("store_rd",  memwb_read_data, 32'h0);
        chk32("store_alu", memwb_alu, 32'h40);

        // Read and write both set: handled as a store
        exmem_alu        = 32'h80;
        exmem_b2         = 32'h55;
        exmem_mem_read   = 1'b1;
        exmem_mem_write  = 1'b1;
        exmem_mem_to_reg = 1'b1;
        tick();
        chk1 ("both_we",    dmem_we, 1'b1);
        chk32("both_addr",  dmem_addr, 32'h80);
        chk32("both_wdata", dmem_wdata, 32'h55);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_0000;
        tick();
        dmem_ack = 1'b0;
        nop();
        chk32("both_rd", memwb_read_data, 32'h0);

        // Branch resolution (combinational)
        exmem_branch = 1'b1;
        exmem_add    = 32'h2C;
        exmem_zf     = 1'b1;
        #1;
        chk1 ("br_taken",  pc_src, 1'b1);
        chk32("br_target", branch_target, 32'h2C);
        exmem_zf = 1'b0;
        #1;
        chk1("br_not_taken", pc_src, 1'b0);
        exmem_zf       = 1'b1;
        exmem_mem_read = 1'b1;
        #1;
        chk1("br_stalled", pc_src, 1'b0);
        nop();
        tick();

        // Reset during the 2nd REQ cycle; a late ack is ignored
        exmem_alu       = 32'h200;
        exmem_mem_read  = 1'b1;
        exmem_reg_write = 1'b1;
        exmem_mux       = 5'd9;
        tick();
        tick();
        chk1("rst_pre_req", dmem_req, 1'b1);
        rst_n = 1'b0;
        tick();
        chk1 ("rst_req",      dmem_req, 1'b0);
        chk32("rst_addr",     dmem_addr, 32'h0);
        chk1 ("rst_memwb_rw", memwb_reg_write, 1'b0);
        chk32("rst_memwb_dest", {27'b0, memwb_dest}, 32'd0);
        rst_n = 1'b1;
        nop();
        exmem_reg_write = 1'b1;
        exmem_mux       = 5'd3;
        exmem_alu       = 32'h33;
        dmem_ack        = 1'b1;
        dmem_rdata      = 32'hBAD0_BAD0;
        #1;
        chk1("late_ack_stall", stall, 1'b0);
        tick();
        dmem_ack = 1'b0;
        nop();
        chk1 ("late_ack_req",  dmem_req, 1'b0);
        chk32("late_ack_rd",   memwb_read_data, 32'h0);
        chk32("late_ack_dest", {27'b0, memwb_dest}, 32'd3);
        chk1 ("late_ack_rw",   memwb_reg_write, 1'b1);

`ifdef MEM_ACK_TIMEOUT_EN
        // Load with no ack: abandoned after 16 REQ cycles
        exmem_alu       = 32'h300;
        exmem_mem_read  = 1'b1;
        exmem_reg_write = 1'b1;
        tick();
        chk1("to_req1_stall", stall, 1'b1);
        repeat (14) tick();
        chk1("to_req15_stall", stall, 1'b1);
        chk1("to_req15_req",   dmem_req, 1'b1);
        tick();
        chk1("to_req16_stall", stall, 1'b0);
        nop();
        tick();
        chk1("to_req_drop", dmem_req, 1'b0);
        chk1("to_err",      mem_err, 1'b1);
        chk1("to_rw",       memwb_reg_write, 1'b0);
        tick();
        chk1("to_err_sticky", mem_err, 1'b1);
`else
        chk1("no_timeout_err", mem_err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
